// File: rtl/iir_dual_sched_if.sv
// Stereo FIFO handshake bundle between the demux FIFOs and the shared IIR scheduler.
interface iir_dual_sched_if #(
  parameter int DATA_SIZE = 32
);
  logic [DATA_SIZE-1:0] l_in;
  logic [DATA_SIZE-1:0] r_in;
  logic                 l_rd_en;
  logic                 r_rd_en;
  logic                 l_empty;
  logic                 r_empty;
  logic [DATA_SIZE-1:0] l_out;
  logic [DATA_SIZE-1:0] r_out;
  logic                 l_wr_en;
  logic                 r_wr_en;
  logic                 l_full;
  logic                 r_full;

  modport master (
    output l_in, r_in, l_empty, r_empty, l_full, r_full,
    input  l_rd_en, r_rd_en, l_out, r_out, l_wr_en, r_wr_en
  );

  modport slave (
    input  l_in, r_in, l_empty, r_empty, l_full, r_full,
    output l_rd_en, r_rd_en, l_out, r_out, l_wr_en, r_wr_en
  );
endinterface

// File: rtl/iir_dual_sched.sv
// Two-channel IIR filter sharing one multiplier: round-robin channel grant,
// one multiply-accumulate step per cycle, per-channel history and decimation.
module iir_dual_sched #(
  parameter int TAPS       = 2,
  parameter int DECIMATION = 1,
  parameter int DATA_SIZE  = 32,
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] X_COEFFS = {32'h000000B2, 32'h000000B2},
  parameter logic [0:TAPS-1][DATA_SIZE-1:0] Y_COEFFS = {32'h00000000, 32'hFFFFFD66}
) (
  input logic          clock,
  input logic          reset,
  iir_dual_sched_if.slave bus
);

  localparam int unsigned KW = $clog2(2 * TAPS);
  localparam int unsigned DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam int unsigned PW = 2 * DATA_SIZE;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Channel index 0 = left, 1 = right.
  logic [DATA_SIZE-1:0] x_hist [2][TAPS];
  logic [DATA_SIZE-1:0] y_hist [2][1:TAPS-1];
  logic [DW-1:0]        dcnt   [2];
  logic [DATA_SIZE-1:0] acc;
  logic [KW-1:0]        k;
  logic                 ch;
  logic                 rr;
  logic [DATA_SIZE-1:0] out_q  [2];
  logic                 wr_q   [2];

  logic [DATA_SIZE-1:0] in_w    [2];
  logic                 empty_w [2];
  logic                 full_w  [2];
  logic                 rd      [2];

  logic                 sel_valid;
  logic                 sel_ch;
  logic                 sel_last;

  logic [DATA_SIZE-1:0] coef;
  logic [DATA_SIZE-1:0] samp;
  logic [PW-1:0]        coef_x;
  logic [PW-1:0]        samp_x;
  logic [PW-1:0]        prod;
  logic [PW-1:0]        mag;
  logic [DATA_SIZE-1:0] trunc;
  logic [DATA_SIZE-1:0] term;

  assign in_w[0]    = bus.l_in;
  assign in_w[1]    = bus.r_in;
  assign empty_w[0] = bus.l_empty;
  assign empty_w[1] = bus.r_empty;
  assign full_w[0]  = bus.l_full;
  assign full_w[1]  = bus.r_full;

  assign bus.l_rd_en = rd[0];
  assign bus.r_rd_en = rd[1];
  assign bus.l_out   = out_q[0];
  assign bus.r_out   = out_q[1];
  assign bus.l_wr_en = wr_q[0];
  assign bus.r_wr_en = wr_q[1];

  // Round-robin pick: the pointed-to channel first, then the other one.
  always_comb begin
    sel_valid = 1'b0;
    sel_ch    = rr;
    if (!empty_w[rr]) begin
      sel_valid = 1'b1;
      sel_ch    = rr;
    end else if (!empty_w[~rr]) begin
      sel_valid = 1'b1;
      sel_ch    = ~rr;
    end
    sel_last = (dcnt[sel_ch] == DW'(DECIMATION - 1));
  end

  // Next-state and pop strobes; pops only happen in ARB.
  always_comb begin
    state_nxt = state;
    rd[0]     = 1'b0;
    rd[1]     = 1'b0;
    case (state)
      ARB: begin
        if (sel_valid) begin
          rd[sel_ch] = 1'b1;
          if (sel_last) state_nxt = MAC;
        end
      end
      MAC: begin
        if (k == KW'(2 * TAPS - 2)) state_nxt = WRITE;
      end
      WRITE: begin
        if (!full_w[ch]) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Operand select for step k, then the shared product with round-toward-zero dequantisation.
  always_comb begin
    coef = '0;
    samp = '0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (k == KW'(i)) begin
        coef = X_COEFFS[i];
        samp = x_hist[ch][i];
      end
    end
    for (int unsigned j = 1; j < TAPS; j++) begin
      if (k == KW'(TAPS + j - 1)) begin
        coef = Y_COEFFS[j];
        samp = y_hist[ch][j];
      end
    end
    coef_x = {{DATA_SIZE{coef[DATA_SIZE-1]}}, coef};
    samp_x = {{DATA_SIZE{samp[DATA_SIZE-1]}}, samp};
    prod   = coef_x * samp_x;
    mag    = prod[PW-1] ? (PW'(0) - prod) : prod;
    trunc  = DATA_SIZE'(mag >> 10);
    term   = prod[PW-1] ? (DATA_SIZE'(0) - trunc) : trunc;
  end

  // Datapath: history shifts on pop, accumulation in MAC, output push in WRITE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < 2; c++) begin
        for (int unsigned i = 0; i < TAPS; i++) x_hist[c][i] <= '0;
        for (int unsigned j = 1; j < TAPS; j++) y_hist[c][j] <= '0;
        dcnt[c]  <= '0;
        out_q[c] <= '0;
        wr_q[c]  <= 1'b0;
      end
      acc <= '0;
      k   <= '0;
      ch  <= 1'b0;
      rr  <= 1'b0;
    end else begin
      wr_q[0] <= 1'b0;
      wr_q[1] <= 1'b0;
      case (state)
        ARB: begin
          if (sel_valid) begin
            x_hist[sel_ch][0] <= in_w[sel_ch];
            for (int unsigned i = 1; i < TAPS; i++) x_hist[sel_ch][i] <= x_hist[sel_ch][i-1];
            ch <= sel_ch;
            rr <= ~sel_ch;
            if (sel_last) begin
              dcnt[sel_ch] <= '0;
              acc          <= '0;
              k            <= '0;
            end else begin
              dcnt[sel_ch] <= dcnt[sel_ch] + DW'(1);
            end
          end
        end
        MAC: begin
          acc <= acc + term;
          k   <= k + KW'(1);
        end
        WRITE: begin
          if (!full_w[ch]) begin
            out_q[ch]     <= acc;
            wr_q[ch]      <= 1'b1;
            y_hist[ch][1] <= acc;
            for (int unsigned j = 2; j < TAPS; j++) y_hist[ch][j] <= y_hist[ch][j-1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
